// File: rtl/key_event_decoder.sv
// Classifies a debounced key level into one-cycle short_press / long_press / double_click pulses.
// Optional macro KEY_EVENT_REPEAT_EN: long_press re-pulses every REPEAT_CNT cycles while held.
module key_event_decoder #(
  parameter int         LONG_CNT   = 50_000_000,
  parameter int         DCLK_CNT   = 15_000_000,
  parameter logic       ACTIVE_LVL = 1'b1,
  parameter int         REPEAT_CNT = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);

  localparam int CNT_MAX_LD = (LONG_CNT > DCLK_CNT) ? LONG_CNT : DCLK_CNT;
  localparam int CNT_MAX    = (CNT_MAX_LD > REPEAT_CNT) ? CNT_MAX_LD : REPEAT_CNT;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] DCLK_TERM = CNT_W'(DCLK_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(CNT_MAX);
`ifdef KEY_EVENT_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(REPEAT_CNT - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_HOLD,
    S_WAIT,
    S_PRESS2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             key_d;
  logic             pressed, press_edge, release_edge;
  logic             short_nxt, long_nxt, dclk_nxt;

  assign pressed      = (key_i == ACTIVE_LVL);
  assign press_edge   = pressed & ~key_d;
  assign release_edge = ~pressed & key_d;
  assign cnt_inc      = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dclk_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (press_edge) state_nxt = S_PRESS1;
      end
      S_PRESS1: begin
        if (release_edge) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
        end else if (pressed && cnt == LONG_TERM) begin
          long_nxt  = 1'b1;
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
        end
      end
      S_HOLD: begin
        if (release_edge) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
`ifdef KEY_EVENT_REPEAT_EN
          if (cnt == REP_TERM) begin
            long_nxt = 1'b1;
            cnt_nxt  = '0;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      S_WAIT: begin
        // A press landing on the terminal-count cycle still counts as the second click.
        if (press_edge) begin
          state_nxt = S_PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == DCLK_TERM) begin
          short_nxt = 1'b1;
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_PRESS2: begin
        cnt_nxt = '0;
        if (release_edge) begin
          dclk_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      key_d        <= 1'b0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      key_d        <= pressed;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dclk_nxt;
      busy         <= (state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with LONG_CNT=50, DCLK_CNT=20, REPEAT_CNT=10.
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst_n;
  logic key_i;
  logic short_press, long_press, double_click, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int n_short = 0, n_long = 0, n_dclk = 0, n_multi = 0;
  int short_last = -1, long_last = -1, dclk_last = -1;

  key_event_decoder #(
    .LONG_CNT  (50),
    .DCLK_CNT  (20),
    .ACTIVE_LVL(1'b1),
    .REPEAT_CNT(10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_i       (key_i),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse recorder: cyc holds the index of the edge that registered the pulse.
  always @(posedge clk) begin
    #2;
    if (short_press)  begin n_short++; short_last = cyc; end
    if (long_press)   begin n_long++;  long_last  = cyc; end
    if (double_click) begin n_dclk++;  dclk_last  = cyc; end
    if ((int'(short_press) + int'(long_press) + int'(double_click)) > 1) n_multi++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Key level v is sampled at edges start .. start+n-1.
  task automatic drive(input logic v, input int n, output int start);
    @(negedge clk);
    key_i = v;
    start = cyc + 1;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    int e0, e1, r0, r2, tmp;
    int s_short, s_long, s_dclk;

    rst_n = 1'b0;
    key_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_short", short_press, 0);
    chk("rst_long", long_press, 0);
    chk("rst_dclk", double_click, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Short press
    s_short = n_short; s_long = n_long; s_dclk = n_dclk;
    drive(1'b1, 10, e0);
    chk("short_busy_hi", busy, 1);
    drive(1'b0, 40, r0);
    chk("short_count", n_short - s_short, 1);
    chk("short_time", short_last, r0 + 20);
    chk("short_no_long", n_long - s_long, 0);
    chk("short_no_dclk", n_dclk - s_dclk, 0);
    chk("short_busy_lo", busy, 0);

    // Long press, 80 cycles
    s_short = n_short; s_long = n_long;
    drive(1'b1, 80, e0);
    drive(1'b0, 10, tmp);
`ifdef KEY_EVENT_REPEAT_EN
    chk("long_count", n_long - s_long, 3);
    chk("long_time", long_last, e0 + 70);
`else
    chk("long_count", n_long - s_long, 1);
    chk("long_time", long_last, e0 + 50);
`endif
    chk("long_no_short", n_short - s_short, 0);
    chk("long_busy_lo", busy, 0);

    // Double click
    s_short = n_short; s_long = n_long; s_dclk = n_dclk;
    drive(1'b1, 10, tmp);
    drive(1'b0, 5, tmp);
    drive(1'b1, 10, tmp);
    drive(1'b0, 30, r2);
    chk("dclk_count", n_dclk - s_dclk, 1);
    chk("dclk_time", dclk_last, r2);
    chk("dclk_no_short", n_short - s_short, 0);
    chk("dclk_no_long", n_long - s_long, 0);

    // Second press edge exactly on the terminal-count cycle
    s_short = n_short; s_dclk = n_dclk;
    drive(1'b1, 10, tmp);
    drive(1'b0, 20, r0);
    drive(1'b1, 10, tmp);
    drive(1'b0, 30, r2);
    chk("tie_dclk_count", n_dclk - s_dclk, 1);
    chk("tie_dclk_time", dclk_last, r2);
    chk("tie_no_short", n_short - s_short, 0);

    // One cycle too late: short fires, then the press starts a new sequence
    s_short = n_short; s_dclk = n_dclk;
    drive(1'b1, 10, tmp);
    drive(1'b0, 21, r0);
    drive(1'b1, 10, tmp);
    drive(1'b0, 30, r2);
    chk("late_short_count", n_short - s_short, 2);
    chk("late_short_time", short_last, r2 + 20);
    chk("late_no_dclk", n_dclk - s_dclk, 0);

    // Reset mid-PRESS1 with the key still held
    s_short = n_short; s_long = n_long; s_dclk = n_dclk;
    drive(1'b1, 31, e0);
    chk("mid_busy_hi", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_short", short_press, 0);
    chk("mid_rst_long", long_press, 0);
    chk("mid_rst_dclk", double_click, 0);
    chk("mid_rst_busy", busy, 0);
    rst_n = 1'b1;
    e1 = cyc + 1;
    repeat (54) @(negedge clk);
    drive(1'b0, 30, tmp);
    chk("mid_long_count", n_long - s_long, 1);
    chk("mid_long_time", long_last, e1 + 50);
    chk("mid_no_other", (n_short - s_short) + (n_dclk - s_dclk), 0);

    // Hold 85 cycles
    s_long = n_long; s_short = n_short;
    drive(1'b1, 85, e0);
    drive(1'b0, 30, tmp);
`ifdef KEY_EVENT_REPEAT_EN
    chk("rep_count", n_long - s_long, 4);
    chk("rep_time", long_last, e0 + 80);
`else
    chk("rep_count", n_long - s_long, 1);
    chk("rep_time", long_last, e0 + 50);
`endif
    chk("rep_no_short", n_short - s_short, 0);

    chk("one_hot_pulses", n_multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
